cv32e41s_obi_data_responder: RTL and testbench

- OBI data-interface responder (subordinate end), the counterpart of the LSU-side initiator.
- Accepts OBI data requests, performs them on a single-port SRAM with 1-cycle read latency, and returns in-order responses.
- Responses can be held off by a stall input; held responses are buffered.
- Used as the data-memory model in core testbenches and as a TCM front-end; also flags initiator protocol violations.

---
 rtl/cv32e41s_obi_data_responder_pkg.sv | 12 +
 rtl/cv32e41s_obi_resp_fifo.sv | 50 +++++
 rtl/cv32e41s_obi_data_responder.sv | 117 +++++++++++
 tb/tb_cv32e41s_obi_data_responder.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cv32e41s_obi_data_responder_pkg.sv
// Shared types for the OBI data responder: response entry layout and default depth.
package cv32e41s_obi_data_responder_pkg;

    localparam int unsigned OBI_DEPTH_DEFAULT = 2;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        we;
    } obi_resp_entry_t;

endpackage

// File: rtl/cv32e41s_obi_resp_fifo.sv
// Response FIFO for the OBI data responder; holds responses while the initiator stalls.
module cv32e41s_obi_resp_fifo
    import cv32e41s_obi_data_responder_pkg::*;
#(
    parameter int unsigned DEPTH = OBI_DEPTH_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  obi_resp_entry_t push_data,
    input  logic            pop,
    output obi_resp_entry_t pop_data,
    output logic            empty,
    output logic            full
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    obi_resp_entry_t  mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, rptr_q;
    logic [CNT_W-1:0] count_q;

    // Pointers wrap modulo DEPTH so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= wrap_inc(wptr_q);
            if (pop)  rptr_q <= wrap_inc(rptr_q);
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= push_data;
    end

    assign pop_data = mem_q[rptr_q];
    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/cv32e41s_obi_data_responder.sv
// OBI data-interface responder: serves requests from a 1-cycle-latency SRAM and returns
// in-order responses, buffering them while stall_i is high; flags unstable requests.
module cv32e41s_obi_data_responder
    import cv32e41s_obi_data_responder_pkg::*;
#(
    parameter int unsigned DEPTH     = OBI_DEPTH_DEFAULT,
    parameter logic [31:0] MEM_BASE  = 32'h0000_0000,
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_i,
    output logic                         gnt_o,
    input  logic [31:0]                  addr_i,
    input  logic                         we_i,
    input  logic [3:0]                   be_i,
    input  logic [31:0]                  wdata_i,
    output logic                         rvalid_o,
    output logic [31:0]                  rdata_o,
    output logic                         err_o,
    input  logic                         stall_i,
    output logic                         mem_req_o,
    output logic                         mem_we_o,
    output logic [$clog2(MEM_WORDS)-1:0] mem_addr_o,
    output logic [3:0]                   mem_be_o,
    output logic [31:0]                  mem_wdata_o,
    input  logic [31:0]                  mem_rdata_i,
    output logic                         busy_o,
    output logic                         protocol_err_o
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic             accept, addr_err;
    logic [30:0]      word_diff;
    logic             cap_valid_q, cap_we_q, cap_err_q;
    obi_resp_entry_t  cap_entry, head_entry, resp_entry;
    logic             fifo_push, fifo_pop, fifo_empty, fifo_full;
    logic             req_q, we_q;
    logic [31:0]      addr_q, wdata_q;
    logic [3:0]       be_q;

    assign gnt_o  = req_i && (outstanding_q < CNT_W'(DEPTH));
    assign accept = req_i && gnt_o;

    // Word-granular offset; the extra top bit catches addresses below MEM_BASE.
    assign word_diff = {1'b0, addr_i[31:2]} - {1'b0, MEM_BASE[31:2]};
    assign addr_err  = word_diff[30] || (word_diff[29:0] >= 30'(MEM_WORDS))
                       || (addr_i[1:0] != 2'b00);

    assign mem_req_o   = accept && !addr_err;
    assign mem_we_o    = we_i;
    assign mem_addr_o  = word_diff[$clog2(MEM_WORDS)-1:0];
    assign mem_be_o    = be_i;
    assign mem_wdata_o = wdata_i;

    always_comb begin
        cap_entry.rdata = (!cap_we_q && !cap_err_q) ? mem_rdata_i : '0;
        cap_entry.err   = cap_err_q;
        cap_entry.we    = cap_we_q;
    end

    // Capture entry bypasses the FIFO only when nothing older is waiting.
    assign rvalid_o   = !stall_i && (cap_valid_q || !fifo_empty);
    assign fifo_push  = cap_valid_q && !(fifo_empty && !stall_i);
    assign fifo_pop   = rvalid_o && !fifo_empty;
    assign resp_entry = fifo_empty ? cap_entry : head_entry;
    assign rdata_o    = (rvalid_o && !resp_entry.we) ? resp_entry.rdata : '0;
    assign err_o      = rvalid_o && resp_entry.err;

    assign outstanding_d = outstanding_q + CNT_W'(accept) - CNT_W'(rvalid_o);
    assign busy_o        = (outstanding_q != '0) || cap_valid_q;

    assign protocol_err_o = req_q && (!req_i || (addr_i != addr_q) || (we_i != we_q)
                                      || (be_i != be_q) || (wdata_i != wdata_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding_q <= '0;
            cap_valid_q   <= 1'b0;
            cap_we_q      <= 1'b0;
            cap_err_q     <= 1'b0;
            req_q         <= 1'b0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            be_q          <= '0;
            wdata_q       <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            cap_valid_q   <= accept;
            cap_we_q      <= we_i;
            cap_err_q     <= addr_err;
            req_q         <= req_i && !gnt_o;
            if (req_i && !gnt_o) begin
                we_q    <= we_i;
                addr_q  <= addr_i;
                be_q    <= be_i;
                wdata_q <= wdata_i;
            end
        end
    end

    cv32e41s_obi_resp_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (fifo_push),
        .push_data(cap_entry),
        .pop      (fifo_pop),
        .pop_data (head_entry),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

endmodule

// File: tb/tb_cv32e41s_obi_data_responder.sv
// Directed bench for the OBI data responder with an SRAM model and a response scoreboard.
`timescale 1ns/1ps
module tb_cv32e41s_obi_data_responder;
    import cv32e41s_obi_data_responder_pkg::*;

    localparam int unsigned DEPTH     = 2;
    localparam logic [31:0] MEM_BASE  = 32'h0000_0000;
    localparam int unsigned MEM_WORDS = 1024;
    localparam int unsigned AW        = $clog2(MEM_WORDS);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_i, gnt_o, we_i, rvalid_o, err_o, stall_i;
    logic [31:0]   addr_i, wdata_i, rdata_o;
    logic [3:0]    be_i, mem_be_o;
    logic          mem_req_o, mem_we_o, busy_o, protocol_err_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_wdata_o, mem_rdata;

    logic [31:0] sram    [MEM_WORDS];
    logic [31:0] ref_mem [MEM_WORDS];

    int n_cmp = 0;
    int n_bad = 0;
    obi_resp_entry_t exp_q[$];
    logic s_gnt, s_rvalid, s_perr;

    always #5 clk = ~clk;

    cv32e41s_obi_data_responder #(
        .DEPTH    (DEPTH),
        .MEM_BASE (MEM_BASE),
        .MEM_WORDS(MEM_WORDS)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_i         (req_i),
        .gnt_o         (gnt_o),
        .addr_i        (addr_i),
        .we_i          (we_i),
        .be_i          (be_i),
        .wdata_i       (wdata_i),
        .rvalid_o      (rvalid_o),
        .rdata_o       (rdata_o),
        .err_o         (err_o),
        .stall_i       (stall_i),
        .mem_req_o     (mem_req_o),
        .mem_we_o      (mem_we_o),
        .mem_addr_o    (mem_addr_o),
        .mem_be_o      (mem_be_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_rdata_i   (mem_rdata),
        .busy_o        (busy_o),
        .protocol_err_o(protocol_err_o)
    );

    function automatic logic [31:0] pattern(input int i);
        return 32'hA5A5_0000 ^ 32'(i * 7 + 3);
    endfunction

    // SRAM model: contents reload while reset is held.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_WORDS; i++) sram[i] <= pattern(i);
        end else if (mem_req_o) begin
            if (mem_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be_o[b]) sram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
            end else begin
                mem_rdata <= sram[mem_addr_o];
            end
        end
    end

    task automatic reinit_ref();
        for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = pattern(i);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic drive(input logic r, input logic [31:0] a, input logic w, input logic [3:0] b,
                         input logic [31:0] d);
        req_i = r; addr_i = a; we_i = w; be_i = b; wdata_i = d;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    endtask

    // One clock: sample at negedge, score responses, record accepted requests.
    task automatic cycle();
        obi_resp_entry_t e;
        longint          a;
        logic            err;
        logic [31:0]     idx;
        @(negedge clk);
        s_gnt    = gnt_o;
        s_rvalid = rvalid_o;
        s_perr   = protocol_err_o;
        n_cmp++;
        assert (!(dut.u_fifo.push && dut.u_fifo.full)) else begin
            n_bad++;
            $error("FAIL fifo_push_full: push=%b full=%b expected no push while full",
                   dut.u_fifo.push, dut.u_fifo.full);
        end
        if (rvalid_o) begin
            n_cmp++;
            assert (exp_q.size() != 0) else begin
                n_bad++;
                $error("FAIL spurious_rvalid: observed rvalid=1 expected 0 (nothing pending)");
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("resp_rdata", rdata_o, e.rdata);
                check("resp_err", 32'(err_o), 32'(e.err));
            end
        end
        if (req_i && gnt_o) begin
            a   = longint'(addr_i);
            err = (a < longint'(MEM_BASE)) || (a >= longint'(MEM_BASE) + 4 * longint'(MEM_WORDS))
                  || (addr_i[1:0] != 2'b00);
            idx = (addr_i - MEM_BASE) >> 2;
            check("mem_req", 32'(mem_req_o), 32'(!err));
            e.we    = we_i;
            e.err   = err;
            e.rdata = 32'h0;
            if (!err) begin
                check("mem_addr", 32'(mem_addr_o), idx);
                if (!we_i) e.rdata = ref_mem[idx];
                else
                    for (int b = 0; b < 4; b++)
                        if (be_i[b]) ref_mem[idx][8*b +: 8] = wdata_i[8*b +: 8];
            end
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        stall_i = 1'b0;
        idle();
        reinit_ref();
        repeat (3) cycle();
        check("rst_rvalid", 32'(rvalid_o), 32'h0);
        check("rst_busy", 32'(busy_o), 32'h0);
        check("rst_outstanding", 32'(dut.outstanding_q), 32'h0);
        check("rst_perr", 32'(protocol_err_o), 32'h0);
        check("rst_rdata", rdata_o, 32'h0);
        rst_n = 1'b1;

        // Store then load, no stall
        drive(1'b1, 32'h10, 1'b1, 4'hF, 32'hDEAD_BEEF); cycle();
        check("st_gnt", 32'(s_gnt), 32'h1);
        idle(); cycle();
        check("st_latency", 32'(s_rvalid), 32'h1);
        drive(1'b1, 32'h10, 1'b0, 4'hF, 32'h0); cycle();
        idle(); cycle();
        check("ld_latency", 32'(s_rvalid), 32'h1);

        // Out of range and misaligned accesses
        drive(1'b1, MEM_BASE + 4 * MEM_WORDS, 1'b0, 4'hF, 32'h0); cycle();
        idle(); cycle();
        check("oor_latency", 32'(s_rvalid), 32'h1);
        drive(1'b1, 32'h12, 1'b0, 4'hF, 32'h0); cycle();
        idle(); cycle();

        // Partial-lane store, be=0 store, then back-to-back readback
        drive(1'b1, 32'h20, 1'b1, 4'b0011, 32'h1234_5678); cycle();
        drive(1'b1, 32'h24, 1'b1, 4'b0000, 32'hFFFF_FFFF); cycle();
        drive(1'b1, 32'h20, 1'b0, 4'hF, 32'h0); cycle();
        drive(1'b1, 32'h24, 1'b0, 4'hF, 32'h0); cycle();
        idle(); cycle();
        cycle();

        // Stall with three back-to-back loads
        stall_i = 1'b1;
        drive(1'b1, 32'h10, 1'b0, 4'hF, 32'h0); cycle();
        check("stl_gnt0", 32'(s_gnt), 32'h1);
        drive(1'b1, 32'h14, 1'b0, 4'hF, 32'h0); cycle();
        check("stl_gnt1", 32'(s_gnt), 32'h1);
        drive(1'b1, 32'h18, 1'b0, 4'hF, 32'h0); cycle();
        check("stl_gnt_full", 32'(s_gnt), 32'h0);
        check("stl_rvalid", 32'(s_rvalid), 32'h0);
        cycle();
        check("stl_hold_gnt", 32'(s_gnt), 32'h0);
        check("stl_busy", 32'(busy_o), 32'h1);
        check("stl_perr", 32'(s_perr), 32'h0);
        stall_i = 1'b0; cycle();
        check("rel_rvalid0", 32'(s_rvalid), 32'h1);
        check("rel_gnt0", 32'(s_gnt), 32'h0);
        cycle();
        check("rel_rvalid1", 32'(s_rvalid), 32'h1);
        check("rel_gnt1", 32'(s_gnt), 32'h1);
        idle(); cycle();
        check("rel_rvalid2", 32'(s_rvalid), 32'h1);

        // Sustained requests: grant and response every cycle
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 32'h30 + 32'(4 * i), 1'b0, 4'hF, 32'h0); cycle();
            check("sus_gnt", 32'(s_gnt), 32'h1);
            if (i > 0) check("sus_rvalid", 32'(s_rvalid), 32'h1);
            check("sus_outstanding", 32'(dut.outstanding_q), 32'h1);
        end
        idle(); cycle();
        check("sus_drain", 32'(dut.outstanding_q), 32'h0);

        // Protocol violations while saturated
        stall_i = 1'b1;
        drive(1'b1, 32'h50, 1'b0, 4'hF, 32'h0); cycle();
        drive(1'b1, 32'h54, 1'b0, 4'hF, 32'h0); cycle();
        drive(1'b1, 32'h40, 1'b0, 4'hF, 32'h0); cycle();
        check("pe_nogrant", 32'(s_gnt), 32'h0);
        check("pe_first", 32'(s_perr), 32'h0);
        idle(); cycle();
        check("pe_drop", 32'(s_perr), 32'h1);
        cycle();
        check("pe_once", 32'(s_perr), 32'h0);
        drive(1'b1, 32'h44, 1'b0, 4'hF, 32'h0); cycle();
        check("pe_new", 32'(s_perr), 32'h0);
        drive(1'b1, 32'h48, 1'b0, 4'hF, 32'h0); cycle();
        check("pe_addr_chg", 32'(s_perr), 32'h1);
        cycle();
        check("pe_stable", 32'(s_perr), 32'h0);
        stall_i = 1'b0; cycle();
        check("pe_rel_rvalid", 32'(s_rvalid), 32'h1);
        check("pe_rel_perr", 32'(s_perr), 32'h0);
        cycle();
        check("pe_rel_gnt", 32'(s_gnt), 32'h1);
        idle(); cycle();
        cycle();
        check("pe_idle_busy", 32'(busy_o), 32'h0);

        // Reset with responses queued
        stall_i = 1'b1;
        drive(1'b1, 32'h10, 1'b0, 4'hF, 32'h0); cycle();
        drive(1'b1, 32'h14, 1'b0, 4'hF, 32'h0); cycle();
        idle(); cycle();
        check("mr_busy", 32'(busy_o), 32'h1);
        rst_n = 1'b0;
        exp_q.delete();
        reinit_ref();
        cycle();
        cycle();
        rst_n = 1'b1;
        stall_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("mr_rvalid", 32'(s_rvalid), 32'h0);
            check("mr_busy0", 32'(busy_o), 32'h0);
            check("mr_outstanding", 32'(dut.outstanding_q), 32'h0);
        end
        drive(1'b1, 32'h10, 1'b0, 4'hF, 32'h0); cycle();
        idle(); cycle();
        check("mr_load_after", 32'(s_rvalid), 32'h1);
        cycle();

        check("sb_empty", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
